// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width and counter sizing.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DataBits = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  // Width of a counter that spans 0..clks-1.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous input pins.
module sync_2ff #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with one-cycle result strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned ClksPerBit = 104
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                uart_rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                valid_o,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                busy_o
);

  localparam int unsigned CntW = cnt_width(ClksPerBit);
  localparam int unsigned IdxW = $clog2(DataBits);
  localparam logic [CntW-1:0] Half    = CntW'((ClksPerBit - 1) / 2);
  localparam logic [CntW-1:0] Last    = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

  uart_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;
  logic                rx_s;
  logic                parity_ok;

  sync_2ff #(
    .RstVal(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (uart_rx_i),
    .q_o   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign parity_ok = ~(^{shreg_q, par_q});
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      // Leaving START at mid-bit re-anchors every later sample to mid-bit.
      StStart: begin
        if (cnt_q == Half) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == Last) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DataBits-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
        if (cnt_q == Last) begin
          cnt_d   = '0;
          state_d = StStop;
`ifdef UART_RX_PARITY_EN
          par_d   = rx_s;
`endif
        end
      end
      StStop: begin
        if (cnt_q == Last) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
            if (parity_ok) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each frame driven pushes its expected strobe,
// the negedge monitor pops and compares whenever a strobe appears.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned Cpb = 16;
  localparam logic [1:0] KValid = 2'd1;
  localparam logic [1:0] KFerr  = 2'd2;
  localparam logic [1:0] KPerr  = 2'd3;

  logic       clk, rst_n, rx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(
    .ClksPerBit(Cpb)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .uart_rx_i   (rx),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] last_good;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] kind;
    logic [9:0] e;
    if (rst_n && (valid || frame_err || parity_err)) begin
      check_eq("strobe_onehot", 32'($countones({valid, frame_err, parity_err})), 32'd1);
      kind = valid ? KValid : (frame_err ? KFerr : KPerr);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'(kind), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_kind", 32'(kind), 32'(e[9:8]));
        check_eq("strobe_data", 32'(data), 32'(e[7:0]));
        check_eq("busy_at_strobe", 32'(busy), 32'(kind == KFerr));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_clks(n);
  endtask

  // Fast mode alternates 16/15-clock bits: a transmitter ~3% fast.
  function automatic int bit_len(input int i, input bit fast);
    if (!fast) return Cpb;
    return ((i % 2) == 0) ? 16 : 15;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input bit fast);
    int i;
    if (!stop_ok) exp_q.push_back({KFerr, last_good});
    else if (!par_ok) exp_q.push_back({KPerr, last_good});
    else begin
      exp_q.push_back({KValid, d});
      last_good = d;
    end
    i = 0;
    drive_bit(1'b0, bit_len(i++, fast));
    for (int b = 0; b < 8; b++) drive_bit(d[b], bit_len(i++, fast));
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok, bit_len(i++, fast));
`endif
    drive_bit(stop_ok, bit_len(i++, fast));
  endtask

  initial begin
    logic [7:0] abort_byte;
    rx        = 1'b1;
    rst_n     = 1'b0;
    last_good = 8'h00;
    wait_clks(3);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_frame_err", 32'(frame_err), 32'h0);
    check_eq("rst_parity_err", 32'(parity_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_clks(20);

    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    wait_clks(2 * Cpb);
    check_eq("idle_after_aa", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    wait_clks(2 * Cpb);

    // Short low glitch must be rejected at the mid-start check.
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 3);
    check_eq("glitch_busy", 32'(busy), 32'h1);
    wait_clks(20);
    check_eq("glitch_idle", 32'(busy), 32'h0);
    check_eq("glitch_data", 32'(data), 32'(last_good));

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      drive_bit(1'b0, Cpb);
      if (k % 10 == 9) check_eq("break_busy", 32'(busy), 32'h1);
    end
    drive_bit(1'b1, 10);
    check_eq("break_released", 32'(busy), 32'h0);
    check_eq("break_data", 32'(data), 32'(last_good));
    wait_clks(2 * Cpb);

    // Back-to-back frames from a slightly fast transmitter.
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 3 * Cpb);
    check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 aborts the frame silently.
    abort_byte = 8'h5A;
    drive_bit(1'b0, Cpb);
    for (int b = 0; b < 4; b++) drive_bit(abort_byte[b], Cpb);
    drive_bit(abort_byte[4], 8);
    rst_n = 1'b0;
    wait_clks(2);
    check_eq("abort_data", 32'(data), 32'h0);
    check_eq("abort_busy", 32'(busy), 32'h0);
    rst_n     = 1'b1;
    rx        = 1'b1;
    last_good = 8'h00;
    wait_clks(2 * Cpb);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    wait_clks(2 * Cpb);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    wait_clks(2 * Cpb);
    check_eq("par_data_held", 32'(data), 32'hC3);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_clks(2 * Cpb);
`endif

    wait_clks(3 * Cpb);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_idle", 32'(busy), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
